network_sequencer: RTL and testbench
====================================

# network_sequencer

Sequences one stochastic inference of the bitstream `network` block. It holds the network in reset while idle and pulses `load_inputs` so the input integers are latched. It then runs a warm-up period so the generator, layer and integrator pipeline settles, flushes the integrators, runs a fixed-length counting window, and captures the result. It sits between the host/test harness and `network`, and drives that block's `n_rst` and `compute` pins.

## Interface
- `WARMUP_CYCLES`, default 4: bitstream cycles discarded before the window; must be ≥1.
- `WINDOW_LENGTH`, default 256: counted bitstream cycles per result; must be ≥1.
- `CNT_WIDTH`, default `$clog2(max(WARMUP_CYCLES,WINDOW_LENGTH)+1)`: phase counter width.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request one inference; sampled in IDLE (and in DONE with `SEQ_CONTINUOUS_EN`).
- `abort`  input  1  cancel an inference in progress.
- `net_n_rst`  output  1  active-low reset to `network`; low in IDLE and LOAD.
- `load_inputs`  output  1  one-cycle pulse; external register latches `network_input`.
- `compute`  output  1  one-cycle pulse to the integrator `capture`.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse; network output valid this cycle.
- `window_count`  output  16  completed windows, wraps at 2^16.

## Operation
- States: IDLE, LOAD, WARMUP, RUN, DONE. One phase counter `cnt` of width CNT_WIDTH.
- **IDLE**
  - `net_n_rst`=0.
  - `start`=1 and `abort`=0 → LOAD.
- **LOAD** (1 cycle)
  - `load_inputs`=1, `net_n_rst`=0, `cnt`←0.
  - → WARMUP.
- **WARMUP**
  - `net_n_rst`=1, `cnt` increments.
  - When `cnt`==WARMUP_CYCLES-1: `compute`=1 (flush pulse, result discarded), `cnt`←0, → RUN.
- **RUN**
  - `net_n_rst`=1, `cnt` increments.
  - When `cnt`==WINDOW_LENGTH-1: `compute`=1 (capture pulse), → DONE.
- **DONE** (1 cycle)
  - `done`=1, `net_n_rst`=1, `window_count`+=1.
  - → IDLE.
- `abort`=1 in LOAD/WARMUP/RUN → IDLE next cycle.
  - No `compute` or `done` that cycle.
  - `window_count` unchanged.
  - `net_n_rst` low from the next cycle.
- `abort` is ignored in DONE. In IDLE, `abort` and `start` together → stay IDLE (abort wins).
- `start` is ignored in LOAD/WARMUP/RUN. It is not queued.
- `compute`, `load_inputs` and `done` are never high in the same cycle.

## Timing
- Reset values: state=IDLE, `cnt`=0, `net_n_rst`=0, `load_inputs`=0, `compute`=0, `busy`=0, `done`=0, `window_count`=0.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- With `start` sampled at edge t:
  - LOAD at t+1.
  - WARMUP at t+2 … t+1+W; flush `compute` at t+1+W.
  - RUN at t+2+W … t+1+W+N; capture `compute` at t+1+W+N.
  - `done` at t+2+W+N. W=WARMUP_CYCLES, N=WINDOW_LENGTH.
- Earliest next `start` is sampled in IDLE at t+3+W+N.
- `rst` asserted mid-operation: all outputs take their reset values immediately (asynchronous). `window_count` is cleared.

## Configuration
- `SEQ_CONTINUOUS_EN` defined:
  - In DONE with `start`=1 and `abort`=0 → RUN directly, `cnt`←0.
  - No LOAD, no WARMUP, `net_n_rst` stays high. The previous capture pulse has already cleared the integrator.
  - Back-to-back windows produce `done` every N+1 cycles.
- `SEQ_CONTINUOUS_EN` undefined: DONE always → IDLE and `start` in DONE is ignored.

## Test plan
- Parameters for all scenarios: W=4, N=16.
- Reset, then `start` at cycle 0:
  - `load_inputs` at 1.
  - `net_n_rst` rises at 2.
  - `compute` at 5 and 21.
  - `done` at 22.
  - `busy` high cycles 1–22.
  - `window_count`=1.
- `abort` at cycle 10 (RUN) → IDLE at 11, `net_n_rst`=0 at 11, no further `compute`, no `done`, `window_count` unchanged.
- `start` pulses at cycles 3 and 15 during the run → ignored; exactly one `done`, at 22.
- `start` and `abort` together in IDLE → stays IDLE; `busy`=0, `load_inputs` never pulses.
- `rst` asserted at cycle 8 → `net_n_rst`=0, `busy`=0 and `window_count`=0 immediately; `start` after release → `done` 22 cycles later.
- `SEQ_CONTINUOUS_EN` with `start` held high:
  - `done` at 22, 39, 56.
  - `load_inputs` pulses only once.
  - `window_count`=3 after cycle 56.

Source files
------------

// File: rtl/network_sequencer.sv
// Sequencer for one stochastic inference of the bitstream network: load, warm-up, flush, count window, done.
// Optional macro SEQ_CONTINUOUS_EN: start seen in DONE chains straight into another counting window.
module network_sequencer #(
  parameter int WARMUP_CYCLES = 4,
  parameter int WINDOW_LENGTH = 256,
  parameter int CNT_WIDTH     = $clog2(((WARMUP_CYCLES > WINDOW_LENGTH) ? WARMUP_CYCLES
                                                                        : WINDOW_LENGTH) + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        net_n_rst,
  output logic        load_inputs,
  output logic        compute,
  output logic        busy,
  output logic        done,
  output logic [15:0] window_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WARMUP = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] WARMUP_LAST = CNT_WIDTH'(WARMUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WINDOW_LAST = CNT_WIDTH'(WINDOW_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      window_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == DONE) window_count <= window_count + 16'd1;
    end
  end

  // The counter restarts from zero on every state change, so each phase counts from its first cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !abort) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = abort ? IDLE : WARMUP;
      end
      WARMUP: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WARMUP_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WINDOW_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        cnt_d = '0;
`ifdef SEQ_CONTINUOUS_EN
        // The capture pulse just cleared the integrators, so a new window needs no reload or warm-up.
        state_d = (start && !abort) ? RUN : IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode only registered state and counter; abort therefore takes effect from the next cycle.
  assign busy        = (state_q != IDLE);
  assign net_n_rst   = (state_q == WARMUP) || (state_q == RUN) || (state_q == DONE);
  assign load_inputs = (state_q == LOAD);
  assign done        = (state_q == DONE);
  assign compute     = ((state_q == WARMUP) && (cnt_q == WARMUP_LAST)) ||
                       ((state_q == RUN)    && (cnt_q == WINDOW_LAST));

endmodule

// File: tb/tb_network_sequencer.sv
// Directed bench for network_sequencer (W=4, N=16): timeline expectations plus a queue of expected done cycles.
module tb_network_sequencer;

  localparam int W = 4;
  localparam int N = 16;
  localparam int NO_ABORT = 100000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        net_n_rst, load_inputs, compute, busy, done;
  logic [15:0] window_count;

  int total = 0;
  int fails = 0;
  int exp_wc = 0;
  int exp_q[$];

  network_sequencer #(.WARMUP_CYCLES(W), .WINDOW_LENGTH(N)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .net_n_rst(net_n_rst), .load_inputs(load_inputs), .compute(compute),
    .busy(busy), .done(done), .window_count(window_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {load_inputs, compute, done, busy, net_n_rst} for cycle c, c=1 being the cycle after start is sampled.
  function automatic logic [4:0] exp_sigs(input int c, input int abort_at, input bit hold);
    int cc;
    int k;
    cc = c;
`ifdef SEQ_CONTINUOUS_EN
    if (hold && c > W + N + 2) begin
      k = (c - (W + N + 2)) % (N + 1);
      return {1'b0, k == N, k == 0, 1'b1, 1'b1};
    end
`else
    if (hold) cc = ((c - 1) % (W + N + 3)) + 1;
`endif
    if (c > abort_at) return 5'b0;
    return {cc == 1, (cc == W + 1) || (cc == W + N + 1), cc == W + N + 2,
            (cc >= 1) && (cc <= W + N + 2), (cc >= 2) && (cc <= W + N + 2)};
  endfunction

  task automatic run_seq(input int ncyc, input int abort_at, input bit hold,
                         input int p1, input int p2, input int exp_loads);
    logic [4:0] e;
    int d;
    int loads;
    loads = 0;
    if (hold) begin
      d = W + N + 2;
      while (d < ncyc) begin
        exp_q.push_back(d);
        exp_wc++;
`ifdef SEQ_CONTINUOUS_EN
        d += N + 1;
`else
        d += W + N + 3;
`endif
      end
    end else if (abort_at > W + N + 2) begin
      exp_q.push_back(W + N + 2);
      exp_wc++;
    end
    start = 1'b1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      step();
      start = (hold && cyc < ncyc - 1) || cyc == p1 || cyc == p2;
      abort = (cyc == abort_at);
      if (load_inputs) loads++;
      if (cyc < ncyc) begin
        e = exp_sigs(cyc, abort_at, hold);
        chk($sformatf("load_inputs@%0d", cyc), 32'(load_inputs), 32'(e[4]));
        chk($sformatf("compute@%0d", cyc),     32'(compute),     32'(e[3]));
        chk($sformatf("done@%0d", cyc),        32'(done),        32'(e[2]));
        chk($sformatf("busy@%0d", cyc),        32'(busy),        32'(e[1]));
        chk($sformatf("net_n_rst@%0d", cyc),   32'(net_n_rst),   32'(e[0]));
      end
      if (done) begin
        if (exp_q.size() == 0) chk("done_unexpected", 32'(cyc), 32'd0);
        else                   chk("done_cycle", 32'(cyc), 32'(exp_q.pop_front()));
      end
    end
    start = 1'b0;
    abort = 1'b0;
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("load_pulses", 32'(loads), 32'(exp_loads));
    chk("window_count", 32'(window_count), 32'(exp_wc));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_net_n_rst", 32'(net_n_rst), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_window_count", 32'(window_count), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_load", 32'(load_inputs), 32'd0);
    chk("idle_compute", 32'(compute), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // Single inference.
    run_seq(W + N + 3, NO_ABORT, 1'b0, -1, -1, 1);
    // Abort in RUN at cycle 10.
    run_seq(12, 10, 1'b0, -1, -1, 1);
    // Start pulses while busy are ignored.
    run_seq(W + N + 3, NO_ABORT, 1'b0, 3, 15, 1);

    // Start together with abort in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("start_abort_busy", 32'(busy), 32'd0);
      chk("start_abort_load", 32'(load_inputs), 32'd0);
    end
    start = 1'b0;
    abort = 1'b0;
    step();

    // Asynchronous reset mid-run at cycle 8.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_net_n_rst", 32'(net_n_rst), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_window_count", 32'(window_count), 32'd0);
    chk("async_rst_compute", 32'(compute), 32'd0);
    exp_wc = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    run_seq(W + N + 3, NO_ABORT, 1'b0, -1, -1, 1);

    // Start held high across several windows.
`ifdef SEQ_CONTINUOUS_EN
    run_seq(W + N + 2 + 2 * (N + 1) + 1, NO_ABORT, 1'b1, -1, -1, 1);
`else
    run_seq(W + N + 2 + 2 * (W + N + 3) + 1, NO_ABORT, 1'b1, -1, -1, 3);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
